// File: rtl/bp_fe_fetch_queue_if.sv
// Fetch-queue port bundle: enqueue packet side, dequeue head side and status.
// slave is the queue's own view; master is the producer/consumer view.
interface bp_fe_fetch_queue_if #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int meta_width_p  = 64,
   parameter int msg_width_p   = 3,
   parameter int els_p         = 8,
   parameter int fetch_lanes_p = 2
) ();
   localparam int lcnt_w_lp = $clog2(fetch_lanes_p+1);
   localparam int cnt_w_lp  = $clog2(els_p+1);

   logic                                   enq_v_i;
   logic                                   enq_ready_and_o;
   logic [lcnt_w_lp-1:0]                   enq_count_i;
   logic [fetch_lanes_p*vaddr_width_p-1:0] enq_pc_i;
   logic [fetch_lanes_p*instr_width_p-1:0] enq_instr_i;
   logic [msg_width_p-1:0]                 enq_msg_i;
   logic [meta_width_p-1:0]                enq_meta_i;

   logic                                   deq_v_o;
   logic                                   deq_yumi_i;
   logic [vaddr_width_p-1:0]               deq_pc_o;
   logic [instr_width_p-1:0]               deq_instr_o;
   logic [msg_width_p-1:0]                 deq_msg_o;
   logic [meta_width_p-1:0]                deq_meta_o;

   logic [cnt_w_lp-1:0]                    count_o;
   logic                                   fenced_o;

   modport slave (
      input  enq_v_i, enq_count_i, enq_pc_i, enq_instr_i, enq_msg_i, enq_meta_i, deq_yumi_i,
      output enq_ready_and_o, deq_v_o, deq_pc_o, deq_instr_o, deq_msg_o, deq_meta_o,
             count_o, fenced_o
   );

   modport master (
      output enq_v_i, enq_count_i, enq_pc_i, enq_instr_i, enq_msg_i, enq_meta_i, deq_yumi_i,
      input  enq_ready_and_o, deq_v_o, deq_pc_o, deq_instr_o, deq_msg_o, deq_meta_o,
             count_o, fenced_o
   );
endinterface

// File: rtl/bp_fe_fetch_queue.sv
// Multi-lane FE fetch queue: up to fetch_lanes_p entries in per cycle, one out.
// An accepted exception packet fences further enqueues until it drains.
module bp_fe_fetch_queue #(
   parameter int vaddr_width_p = 39,
   parameter int instr_width_p = 32,
   parameter int meta_width_p  = 64,
   parameter int msg_width_p   = 3,
   parameter int els_p         = 8,
   parameter int fetch_lanes_p = 2
) (
   input logic                clk_i,
   input logic                reset_i,
   input logic                flush_i,
   bp_fe_fetch_queue_if.slave fq
);
   localparam int ptr_w_lp  = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp  = $clog2(els_p+1);
   localparam int lcnt_w_lp = $clog2(fetch_lanes_p+1);

   typedef logic [ptr_w_lp-1:0]  ptr_t;
   typedef logic [cnt_w_lp-1:0]  cnt_t;
   typedef logic [lcnt_w_lp-1:0] lcnt_t;

   // inc never exceeds els_p, so a single conditional subtract wraps correctly
   function automatic ptr_t wrap_add(input ptr_t p, input cnt_t inc);
      int s;
      s = int'(p) + int'(inc);
      if (s >= els_p) s = s - els_p;
      return ptr_t'(s);
   endfunction

   ptr_t head_q, head_d, tail_q, tail_d;
   cnt_t count_q, count_d;
   logic fence_q, fence_d;

   logic [vaddr_width_p-1:0] pc_mem    [els_p];
   logic [instr_width_p-1:0] instr_mem [els_p];
   logic [msg_width_p-1:0]   msg_mem   [els_p];
   logic [meta_width_p-1:0]  meta_mem  [els_p];

   logic enq_ready, enq_hs, is_exc, deq_v, deq_hs;
   cnt_t free_n, lane_n, enq_n;
   ptr_t wr_idx [fetch_lanes_p];

   always_comb begin
      free_n    = cnt_t'(els_p) - count_q;
      enq_ready = reset_i & ~fence_q & (free_n >= cnt_t'(fetch_lanes_p));
      is_exc    = |fq.enq_msg_i;
      enq_hs    = fq.enq_v_i & enq_ready & ~flush_i;
      lane_n    = (fq.enq_count_i > lcnt_t'(fetch_lanes_p)) ? cnt_t'(fetch_lanes_p)
                                                            : cnt_t'(fq.enq_count_i);
      if (!enq_hs)     enq_n = '0;
      else if (is_exc) enq_n = cnt_t'(1);
      else             enq_n = lane_n;
      deq_v  = (count_q != '0);
      deq_hs = fq.deq_yumi_i & deq_v & ~flush_i;
      for (int k = 0; k < fetch_lanes_p; k++) wr_idx[k] = wrap_add(tail_q, cnt_t'(k));
   end

   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      fence_d = fence_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
         fence_d = 1'b0;
      end else begin
         if (deq_hs) begin
            head_d = wrap_add(head_q, cnt_t'(1));
            if (msg_mem[head_q] != '0) fence_d = 1'b0;
         end
         tail_d  = wrap_add(tail_q, enq_n);
         count_d = count_q + enq_n - cnt_t'(deq_hs);
         if (enq_hs && is_exc) fence_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         fence_q <= 1'b0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         fence_q <= fence_d;
      end
   end

   // Storage is not reset; entries are only observed once count covers them
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < fetch_lanes_p; k++) begin
         if (cnt_t'(k) < enq_n) begin
            pc_mem[wr_idx[k]]    <= fq.enq_pc_i[k*vaddr_width_p +: vaddr_width_p];
            instr_mem[wr_idx[k]] <= fq.enq_instr_i[k*instr_width_p +: instr_width_p];
            msg_mem[wr_idx[k]]   <= fq.enq_msg_i;
            meta_mem[wr_idx[k]]  <= fq.enq_meta_i;
         end
      end
   end

   assign fq.enq_ready_and_o = enq_ready;
   assign fq.deq_v_o         = deq_v;
   assign fq.deq_pc_o        = deq_v ? pc_mem[head_q]    : '0;
   assign fq.deq_instr_o     = deq_v ? instr_mem[head_q] : '0;
   assign fq.deq_msg_o       = deq_v ? msg_mem[head_q]   : '0;
   assign fq.deq_meta_o      = deq_v ? meta_mem[head_q]  : '0;
   assign fq.count_o         = count_q;
   assign fq.fenced_o        = fence_q;

   // Exception entries currently resident between head and head+count
   cnt_t exc_res;
   always_comb begin
      exc_res = '0;
      for (int i = 0; i < els_p; i++) begin
         int off;
         off = (i >= int'(head_q)) ? (i - int'(head_q)) : (i + els_p - int'(head_q));
         if ((off < int'(count_q)) && (msg_mem[i] != '0)) exc_res = exc_res + cnt_t'(1);
      end
   end

   a_count_bound: assert property (@(posedge clk_i) disable iff (!reset_i)
                                   count_q <= cnt_t'(els_p));
   a_one_exc:     assert property (@(posedge clk_i) disable iff (!reset_i)
                                   exc_res <= cnt_t'(1));
   a_yumi_legal:  assert property (@(posedge clk_i) disable iff (!reset_i)
                                   !(fq.deq_yumi_i && !deq_v));
endmodule

// File: tb/tb_bp_fe_fetch_queue.sv
// Bench for bp_fe_fetch_queue: an 8-entry and a 5-entry instance, 2 lanes each,
// checked against a scoreboard of expected dequeue order.
module tb_bp_fe_fetch_queue;
   localparam int VW = 39, IW = 32, MW = 64, SW = 3, LANES = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush8 = 1'b0;
   logic flush5 = 1'b0;
   always #5 clk = ~clk;

   bp_fe_fetch_queue_if #(.vaddr_width_p(VW), .instr_width_p(IW), .meta_width_p(MW),
                          .msg_width_p(SW), .els_p(8), .fetch_lanes_p(LANES)) fq8 ();
   bp_fe_fetch_queue_if #(.vaddr_width_p(VW), .instr_width_p(IW), .meta_width_p(MW),
                          .msg_width_p(SW), .els_p(5), .fetch_lanes_p(LANES)) fq5 ();

   bp_fe_fetch_queue #(.vaddr_width_p(VW), .instr_width_p(IW), .meta_width_p(MW),
                       .msg_width_p(SW), .els_p(8), .fetch_lanes_p(LANES))
      dut8 (.clk_i(clk), .reset_i(rst_n), .flush_i(flush8), .fq(fq8.slave));
   bp_fe_fetch_queue #(.vaddr_width_p(VW), .instr_width_p(IW), .meta_width_p(MW),
                       .msg_width_p(SW), .els_p(5), .fetch_lanes_p(LANES))
      dut5 (.clk_i(clk), .reset_i(rst_n), .flush_i(flush5), .fq(fq5.slave));

   typedef struct packed {
      logic [VW-1:0] pc;
      logic [IW-1:0] instr;
      logic [SW-1:0] msg;
      logic [MW-1:0] meta;
   } ent_t;

   int   checks = 0;
   int   failures = 0;
   ent_t sb[$];
   int   m_cnt = 0;
   bit   m_fence = 1'b0;

   function automatic logic [IW-1:0] instr_of(input logic [VW-1:0] pc);
      return pc[31:0] ^ 32'h5A5A_C3C3;
   endfunction

   task automatic idle_inputs();
      fq8.enq_v_i = 1'b0; fq8.enq_count_i = '0; fq8.enq_pc_i = '0; fq8.enq_instr_i = '0;
      fq8.enq_msg_i = '0; fq8.enq_meta_i = '0; fq8.deq_yumi_i = 1'b0; flush8 = 1'b0;
      fq5.enq_v_i = 1'b0; fq5.enq_count_i = '0; fq5.enq_pc_i = '0; fq5.enq_instr_i = '0;
      fq5.enq_msg_i = '0; fq5.enq_meta_i = '0; fq5.deq_yumi_i = 1'b0; flush5 = 1'b0;
   endtask

   // One cycle on the 8-entry queue; updates the scoreboard, returns the head seen
   // before the edge and the entry the scoreboard expected it to be.
   task automatic step8(input bit v, input int n, input logic [VW-1:0] pc0,
                        input logic [SW-1:0] msg, input logic [MW-1:0] meta,
                        input bit yumi, input bit fl,
                        output bit popped, output ent_t exp, output ent_t got);
      bit   y, hs;
      int   en;
      ent_t e;
      y = yumi && (m_cnt != 0);
      fq8.enq_v_i = v;
      fq8.enq_count_i = 2'(n);
      for (int k = 0; k < LANES; k++) begin
         fq8.enq_pc_i[k*VW +: VW]    = pc0 + VW'(4*k);
         fq8.enq_instr_i[k*IW +: IW] = instr_of(pc0 + VW'(4*k));
      end
      fq8.enq_msg_i = msg;
      fq8.enq_meta_i = meta;
      fq8.deq_yumi_i = y;
      flush8 = fl;
      got = '{pc: fq8.deq_pc_o, instr: fq8.deq_instr_o, msg: fq8.deq_msg_o, meta: fq8.deq_meta_o};
      popped = 1'b0;
      exp = '0;
      if (fl) begin
         sb.delete();
         m_cnt = 0;
         m_fence = 1'b0;
      end else begin
         hs = v && !m_fence && ((8 - m_cnt) >= LANES);
         if (y) begin
            exp = sb.pop_front();
            popped = 1'b1;
            m_cnt--;
            if (exp.msg != '0) m_fence = 1'b0;
         end
         if (hs) begin
            en = (msg != '0) ? 1 : n;
            for (int k = 0; k < en; k++) begin
               e.pc = pc0 + VW'(4*k);
               e.instr = instr_of(e.pc);
               e.msg = msg;
               e.meta = meta;
               sb.push_back(e);
            end
            m_cnt += en;
            if (msg != '0) m_fence = 1'b1;
         end
      end
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic drive5(input bit v, input int n, input logic [VW-1:0] pc0, input bit yumi);
      fq5.enq_v_i = v;
      fq5.enq_count_i = 2'(n);
      for (int k = 0; k < LANES; k++) begin
         fq5.enq_pc_i[k*VW +: VW]    = pc0 + VW'(4*k);
         fq5.enq_instr_i[k*IW +: IW] = instr_of(pc0 + VW'(4*k));
      end
      fq5.deq_yumi_i = yumi;
      @(posedge clk); #1;
      idle_inputs();
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk); #1;
         checks++; if (fq8.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL reset_ready8 cyc=%0d got=%0b exp=0", c, fq8.enq_ready_and_o); end
         checks++; if (fq8.count_o !== 4'd0) begin failures++; $display("FAIL reset_count8 cyc=%0d got=%0d exp=0", c, fq8.count_o); end
         checks++; if (fq8.deq_v_o !== 1'b0) begin failures++; $display("FAIL reset_deqv8 cyc=%0d got=%0b exp=0", c, fq8.deq_v_o); end
         checks++; if (fq8.fenced_o !== 1'b0) begin failures++; $display("FAIL reset_fenced8 cyc=%0d got=%0b exp=0", c, fq8.fenced_o); end
         checks++; if (fq5.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL reset_ready5 cyc=%0d got=%0b exp=0", c, fq5.enq_ready_and_o); end
      end
      rst_n = 1'b1;
      #1;
      checks++; if (fq8.enq_ready_and_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready8 got=%0b exp=1", fq8.enq_ready_and_o); end
      checks++; if (fq5.enq_ready_and_o !== 1'b1) begin failures++; $display("FAIL post_reset_ready5 got=%0b exp=1", fq5.enq_ready_and_o); end
      checks++; if (fq8.deq_pc_o !== '0) begin failures++; $display("FAIL post_reset_pc_gated got=%h exp=0", fq8.deq_pc_o); end
      m_cnt = 0;
      m_fence = 1'b0;
      sb.delete();
   endtask

   task automatic test_fill_wrap();
      bit popped; ent_t exp, got;
      for (int r = 0; r < 3; r++) begin
         for (int p = 0; p < 4; p++)
            step8(1'b1, 2, VW'(32'h1000 + 8*p), '0, {$urandom, $urandom}, 1'b0, 1'b0, popped, exp, got);
         checks++; if (fq8.count_o !== 4'd8) begin failures++; $display("FAIL full_count r=%0d got=%0d exp=8", r, fq8.count_o); end
         checks++; if (fq8.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL full_ready r=%0d got=%0b exp=0", r, fq8.enq_ready_and_o); end
         checks++; if (fq8.deq_v_o !== 1'b1) begin failures++; $display("FAIL full_deqv r=%0d got=%0b exp=1", r, fq8.deq_v_o); end
         for (int i = 0; i < 8; i++) begin
            step8(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, popped, exp, got);
            checks++; if (got.pc !== VW'(32'h1000 + 4*i)) begin failures++; $display("FAIL drain_pc r=%0d i=%0d got=%h exp=%h", r, i, got.pc, 32'h1000 + 4*i); end
            checks++; if (got.instr !== exp.instr) begin failures++; $display("FAIL drain_instr r=%0d i=%0d got=%h exp=%h", r, i, got.instr, exp.instr); end
            checks++; if (got.meta !== exp.meta) begin failures++; $display("FAIL drain_meta r=%0d i=%0d got=%h exp=%h", r, i, got.meta, exp.meta); end
         end
         checks++; if (fq8.count_o !== 4'd0) begin failures++; $display("FAIL drained_count r=%0d got=%0d exp=0", r, fq8.count_o); end
      end
   endtask

   task automatic test_partial();
      int cnts[5] = '{0, 1, 2, 1, 0};
      logic [VW-1:0] pcs[$];
      logic [VW-1:0] got, pc0;
      int c = 0;
      bit rdy;
      for (int i = 0; i < 5; i++) begin
         pc0 = VW'(32'h2000 + 32'h100*i);
         rdy = (5 - c) >= LANES;
         checks++; if (fq5.enq_ready_and_o !== rdy) begin failures++; $display("FAIL partial_ready i=%0d got=%0b exp=%0b", i, fq5.enq_ready_and_o, rdy); end
         if (rdy) begin
            for (int k = 0; k < cnts[i]; k++) pcs.push_back(pc0 + VW'(4*k));
            c += cnts[i];
         end
         drive5(1'b1, cnts[i], pc0, 1'b0);
      end
      checks++; if (fq5.count_o !== 3'd4) begin failures++; $display("FAIL partial_count got=%0d exp=4", fq5.count_o); end
      checks++; if (fq5.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL partial_ready_low got=%0b exp=0", fq5.enq_ready_and_o); end
      got = fq5.deq_pc_o;
      drive5(1'b0, 0, '0, 1'b1);
      pc0 = pcs.pop_front();
      checks++; if (got !== pc0) begin failures++; $display("FAIL partial_first_pc got=%h exp=%h", got, pc0); end
      checks++; if (fq5.count_o !== 3'd3) begin failures++; $display("FAIL partial_count_after_yumi got=%0d exp=3", fq5.count_o); end
      checks++; if (fq5.enq_ready_and_o !== 1'b1) begin failures++; $display("FAIL partial_ready_after_yumi got=%0b exp=1", fq5.enq_ready_and_o); end
      drive5(1'b1, 2, VW'(32'h2400), 1'b0);
      pcs.push_back(VW'(32'h2400));
      pcs.push_back(VW'(32'h2404));
      checks++; if (fq5.count_o !== 3'd5) begin failures++; $display("FAIL partial_full_count got=%0d exp=5", fq5.count_o); end
      checks++; if (fq5.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL partial_full_ready got=%0b exp=0", fq5.enq_ready_and_o); end
      for (int i = 0; i < 5; i++) begin
         got = fq5.deq_pc_o;
         drive5(1'b0, 0, '0, 1'b1);
         pc0 = pcs.pop_front();
         checks++; if (got !== pc0) begin failures++; $display("FAIL partial_wrap_pc i=%0d got=%h exp=%h", i, got, pc0); end
      end
      checks++; if (fq5.deq_v_o !== 1'b0) begin failures++; $display("FAIL partial_empty_deqv got=%0b exp=0", fq5.deq_v_o); end
   endtask

   task automatic test_fence();
      bit popped; ent_t exp, got;
      step8(1'b1, 2, VW'(32'h3000), '0, 64'h1111, 1'b0, 1'b0, popped, exp, got);
      step8(1'b1, 2, VW'(32'h3100), 3'd3, 64'h2222, 1'b0, 1'b0, popped, exp, got);
      checks++; if (fq8.count_o !== 4'd3) begin failures++; $display("FAIL fence_count got=%0d exp=3", fq8.count_o); end
      checks++; if (fq8.fenced_o !== 1'b1) begin failures++; $display("FAIL fence_set got=%0b exp=1", fq8.fenced_o); end
      checks++; if (fq8.enq_ready_and_o !== 1'b0) begin failures++; $display("FAIL fence_ready got=%0b exp=0", fq8.enq_ready_and_o); end
      step8(1'b1, 2, VW'(32'h3200), '0, 64'h3333, 1'b0, 1'b0, popped, exp, got);
      checks++; if (fq8.count_o !== 4'd3) begin failures++; $display("FAIL fence_blocks got=%0d exp=3", fq8.count_o); end
      for (int i = 0; i < 3; i++) begin
         step8(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, popped, exp, got);
         checks++; if (got !== exp) begin failures++; $display("FAIL fence_entry i=%0d got=%h/%0d exp=%h/%0d", i, got.pc, got.msg, exp.pc, exp.msg); end
      end
      checks++; if (got.msg !== 3'd3) begin failures++; $display("FAIL fence_third_msg got=%0d exp=3", got.msg); end
      checks++; if (fq8.fenced_o !== 1'b0) begin failures++; $display("FAIL fence_clear got=%0b exp=0", fq8.fenced_o); end
      checks++; if (fq8.enq_ready_and_o !== 1'b1) begin failures++; $display("FAIL fence_ready_back got=%0b exp=1", fq8.enq_ready_and_o); end
   endtask

   task automatic test_flush();
      bit popped; ent_t exp, got;
      step8(1'b1, 2, VW'(32'h4000), '0, 64'h44, 1'b0, 1'b0, popped, exp, got);
      step8(1'b1, 2, VW'(32'h4100), '0, 64'h45, 1'b0, 1'b0, popped, exp, got);
      step8(1'b1, 1, VW'(32'h4200), '0, 64'h46, 1'b0, 1'b0, popped, exp, got);
      step8(1'b1, 1, VW'(32'h4300), 3'd5, 64'h47, 1'b0, 1'b0, popped, exp, got);
      checks++; if (fq8.count_o !== 4'd6) begin failures++; $display("FAIL flush_pre_count got=%0d exp=6", fq8.count_o); end
      checks++; if (fq8.fenced_o !== 1'b1) begin failures++; $display("FAIL flush_pre_fence got=%0b exp=1", fq8.fenced_o); end
      step8(1'b1, 2, VW'(32'h5000), '0, 64'h50, 1'b1, 1'b1, popped, exp, got);
      checks++; if (fq8.count_o !== 4'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", fq8.count_o); end
      checks++; if (fq8.deq_v_o !== 1'b0) begin failures++; $display("FAIL flush_deqv got=%0b exp=0", fq8.deq_v_o); end
      checks++; if (fq8.fenced_o !== 1'b0) begin failures++; $display("FAIL flush_fence got=%0b exp=0", fq8.fenced_o); end
      checks++; if (fq8.enq_ready_and_o !== 1'b1) begin failures++; $display("FAIL flush_ready got=%0b exp=1", fq8.enq_ready_and_o); end
      checks++; if (fq8.deq_pc_o !== '0) begin failures++; $display("FAIL flush_pc_gated got=%h exp=0", fq8.deq_pc_o); end
      step8(1'b1, 2, VW'(32'h6000), '0, 64'h60, 1'b0, 1'b0, popped, exp, got);
      checks++; if (dut8.pc_mem[0] !== VW'(32'h6000)) begin failures++; $display("FAIL flush_slot0 got=%h exp=6000", dut8.pc_mem[0]); end
      checks++; if (fq8.deq_pc_o !== VW'(32'h6000)) begin failures++; $display("FAIL flush_head_pc got=%h exp=6000", fq8.deq_pc_o); end
      for (int i = 0; i < 2; i++) begin
         step8(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, popped, exp, got);
         checks++; if (got !== exp) begin failures++; $display("FAIL flush_drain i=%0d got=%h exp=%h", i, got.pc, exp.pc); end
      end
   endtask

   task automatic test_random();
      bit popped, v, y, fl, rdy;
      int n;
      logic [SW-1:0] msg;
      ent_t exp, got;
      for (int c = 0; c < 10000; c++) begin
         rdy = !m_fence && ((8 - m_cnt) >= LANES);
         checks++; if (fq8.count_o !== 4'(m_cnt)) begin failures++; $display("FAIL rand_count cyc=%0d got=%0d exp=%0d", c, fq8.count_o, m_cnt); end
         checks++; if (fq8.enq_ready_and_o !== rdy) begin failures++; $display("FAIL rand_ready cyc=%0d got=%0b exp=%0b", c, fq8.enq_ready_and_o, rdy); end
         v   = $urandom_range(0, 3) != 0;
         n   = $urandom_range(1, 2);
         msg = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
         y   = $urandom_range(0, 9) < 7;
         fl  = $urandom_range(0, 199) == 0;
         step8(v, n, {7'($urandom), 32'($urandom)}, msg, {$urandom, $urandom}, y, fl, popped, exp, got);
         if (popped) begin
            checks++; if (got !== exp) begin failures++; $display("FAIL rand_entry cyc=%0d got=%h/%h/%0d/%h exp=%h/%h/%0d/%h", c, got.pc, got.instr, got.msg, got.meta, exp.pc, exp.instr, exp.msg, exp.meta); end
         end
      end
      for (int g = 0; g < 64 && m_cnt != 0; g++) begin
         step8(1'b0, 0, '0, '0, '0, 1'b1, 1'b0, popped, exp, got);
         checks++; if (got !== exp) begin failures++; $display("FAIL rand_drain g=%0d got=%h exp=%h", g, got.pc, exp.pc); end
      end
      checks++; if (fq8.count_o !== 4'd0 || m_cnt != 0) begin failures++; $display("FAIL rand_final_count got=%0d exp=0 model=%0d", fq8.count_o, m_cnt); end
   endtask

   initial begin
      test_reset();
      test_fill_wrap();
      test_partial();
      test_fence();
      test_flush();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/bp_fe_fetch_queue.md
Name: bp_fe_fetch_queue

Overview:
- Parametrised multi-lane fetch queue between the FE fetch/realign stage and the fe_queue interface to the BE.
- Accepts packets of up to fetch_lanes_p instructions per cycle and drains one entry per cycle.
- Fetch exceptions (itlb miss, page fault, access fault, icache miss) travel as single-entry packets. After one is accepted, an exception fence blocks further enqueues until that entry is consumed.
- Supports single-cycle flush, used on redirect.

Parameters:
- vaddr_width_p, 39, virtual PC width.
- instr_width_p, 32, instruction width per lane.
- meta_width_p, 64, branch-metadata width per packet.
- msg_width_p, 3, message-type width; value 0 means normal instruction fetch, any nonzero value is an exception.
- els_p, 8, queue depth in entries; any value >= fetch_lanes_p, need not be a power of 2.
- fetch_lanes_p, 2, maximum instructions enqueued per cycle; >= 1.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  synchronous reset, active-low.
- flush_i  in  1  discard all entries and clear the fence.
- enq_v_i  in  1  enqueue packet valid.
- enq_ready_and_o  out  1  queue can accept a full packet this cycle.
- enq_count_i  in  $clog2(fetch_lanes_p+1)  number of valid lanes, contiguous from lane 0.
- enq_pc_i  in  fetch_lanes_p*vaddr_width_p  per-lane PC; lane 0 in the LSBs.
- enq_instr_i  in  fetch_lanes_p*instr_width_p  per-lane instruction.
- enq_msg_i  in  msg_width_p  packet message type.
- enq_meta_i  in  meta_width_p  packet branch metadata, copied into every entry of the packet.
- deq_v_o  out  1  head entry valid.
- deq_yumi_i  in  1  consumer takes the head entry.
- deq_pc_o  out  vaddr_width_p  head entry PC.
- deq_instr_o  out  instr_width_p  head entry instruction.
- deq_msg_o  out  msg_width_p  head entry message type.
- deq_meta_o  out  meta_width_p  head entry metadata.
- count_o  out  $clog2(els_p+1)  current occupancy.
- fenced_o  out  1  an exception entry is resident.

Behaviour:

Reset:
- While reset_i==0 at a clock edge: head pointer, tail pointer, count and fence are cleared to 0.
- During and after reset: deq_v_o=0, count_o=0, fenced_o=0.
- enq_ready_and_o is forced to 0 while reset_i==0.
- Storage arrays are not reset.
- deq_pc_o, deq_instr_o, deq_msg_o and deq_meta_o are gated to 0 whenever deq_v_o==0.

Enqueue:
- enq_ready_and_o = reset_i & ~fence_r & ((els_p - count) >= fetch_lanes_p).
- enq_ready_and_o depends only on registered state; it does not depend on deq_yumi_i or on any enq_* input.
- Handshake occurs on enq_v_i & enq_ready_and_o & ~flush_i.
- Normal packet (enq_msg_i==0): lanes 0..enq_count_i-1 are written at tail, tail+1, ... modulo els_p. Tail advances by enq_count_i.
- enq_count_i==0 with enq_v_i=1 is legal: no entry is written and no state changes.
- Exception packet (enq_msg_i!=0): only lane 0 is written, regardless of enq_count_i (0 is treated as 1). Tail advances by 1 and fence_r is set.
- Enqueued entries become visible at the head no earlier than the next cycle; there is no same-cycle bypass.

Dequeue:
- deq_v_o = (count != 0); head data is read combinationally from storage.
- deq_yumi_i is legal only when deq_v_o=1; asserting it with deq_v_o=0 is an assertion error.
- On yumi, head advances by 1 modulo els_p.
- If the dequeued entry has msg != 0, fence_r clears in the same edge.

Simultaneous enqueue and dequeue:
- count_next = count + enq_n - deq_n, where enq_n is 0..fetch_lanes_p and deq_n is 0 or 1.
- Enqueue readiness is not widened by a same-cycle dequeue.

Flush:
- flush_i has priority over everything. The enqueue handshake and deq_yumi_i in a flush cycle are ignored.
- Next cycle: head = tail = 0, count = 0, fence_r = 0, deq_v_o = 0.
- enq_ready_and_o is 1 in the cycle after the flush, provided reset_i==1.

Wrap-around:
- Pointer arithmetic is modulo els_p. The PC/instr write port for lane k addresses (tail + k) mod els_p, including when els_p is not a power of 2.

Boundaries:
- Full (count==els_p): deq_v_o=1, enq_ready_and_o=0.
- Exactly fetch_lanes_p entries free: ready=1.
- Fence set: ready=0 regardless of free space.

Assertions:
- count never exceeds els_p.
- No more than one entry with msg != 0 is resident at any time.

Test Plan:
- Reset and idle: hold reset_i=0 for 3 cycles, then release -> deq_v_o=0, count_o=0, fenced_o=0; enq_ready_and_o=0 during reset and 1 after.
- Fill, drain and wrap (els_p=8, lanes=2): 4 packets of 2 lanes with PC 0x1000..0x101C, no yumi -> count_o=8, ready=0. Then 8 yumis -> PCs dequeue in order. Repeat 3 times to exercise wrap -> order is preserved.
- Partial packets (els_p=5, lanes=2): enq_count_i sequence 1,2,1,0 -> count_o=4 and ready=0 (1 free < 2). One yumi -> ready=1 the following cycle.
- Exception fence: enqueue 2-lane fetch packet, then exception packet with msg=3 and enq_count_i=2 -> only 3 entries stored, fenced_o=1, ready=0. Dequeue 3 entries -> 3rd has deq_msg_o=3; fenced_o=0 and ready=1 on the next cycle.
- Flush collisions: in the same cycle assert flush_i, a valid enqueue and deq_yumi_i with count=6 and fence set -> next cycle count_o=0, deq_v_o=0, fenced_o=0; the next enqueue lands at index 0.
- Concurrent traffic: random 1–2 lane enqueues and 70% yumi for 10k cycles against a scoreboard -> exact PC, instr, msg and meta order match; count_o equals the model each cycle.
